// File: rtl/altsyncram_sched_pkg.sv
// Shared types for the altsyncram valid-bit port scheduler: read tag record and id width helper.
package altsyncram_sched_pkg;

    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/altsyncram_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the eligible request closest to ptr, scanning upward with wrap.
module rr_arbiter
    import altsyncram_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Distance from ptr in wrap order; the smallest eligible distance wins.
    always_comb begin
        int best;
        int d;
        int p;
        p    = int'(ptr);
        best = N;
        d    = 0;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = (i >= p) ? (i - p) : (i + N - p);
            if (req[i] && mask[i] && d < best) begin
                best = d;
                idx  = IW'(i);
            end
        end
        any = (best < N);
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/altsyncram_port_scheduler.sv
// Shares one write port and one read port of the valid-bit RAM between NUM_REQ writers and readers,
// and routes each fixed-latency read result back to the reader that issued it.
module altsyncram_port_scheduler
    import altsyncram_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTHAD = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           wr_req,
    input  logic [NUM_REQ*WIDTHAD-1:0]   wr_addr,
    input  logic [NUM_REQ-1:0]           wr_valid,
    output logic [NUM_REQ-1:0]           wr_gnt,
    input  logic [NUM_REQ-1:0]           rd_req,
    input  logic [NUM_REQ*WIDTHAD-1:0]   rd_addr,
    output logic [NUM_REQ-1:0]           rd_gnt,
    output logic                         rd_resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rd_resp_id,
    output logic                         rd_resp_data,
    output logic                         wren_a,
    output logic [WIDTHAD-1:0]           address_a,
    output logic                         valid_a,
    output logic [WIDTHAD-1:0]           address_b,
    input  logic                         ram_valid_q_b
);

    localparam int ID_W = id_w(NUM_REQ);

    logic [ID_W-1:0]    wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic               wr_any, rd_any;
    logic [NUM_REQ-1:0] rd_mask;
    logic [WIDTHAD-1:0] rd_sel_addr, addr_b_q;
    rd_tag_t            tag_in;
    rd_tag_t            tag_pipe [RD_LAT];
    logic               unused_tag_id;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] i);
        return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req  (wr_req),
        .mask ({NUM_REQ{1'b1}}),
        .ptr  (wr_ptr),
        .gnt  (wr_gnt),
        .idx  (wr_idx),
        .any  (wr_any)
    );

    assign wren_a  = wr_any;
    assign valid_a = |(wr_gnt & wr_valid);

    always_comb begin
        address_a = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (wr_gnt[i]) address_a = wr_addr[i*WIDTHAD +: WIDTHAD];
    end

    // A reader targeting the address being written this edge would see stale data; hold it off a cycle.
    always_comb begin
        rd_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rd_mask[i] = !(wren_a && (rd_addr[i*WIDTHAD +: WIDTHAD] == address_a));
    end

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req  (rd_req),
        .mask (rd_mask),
        .ptr  (rd_ptr),
        .gnt  (rd_gnt),
        .idx  (rd_idx),
        .any  (rd_any)
    );

    always_comb begin
        rd_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rd_gnt[i]) rd_sel_addr = rd_addr[i*WIDTHAD +: WIDTHAD];
    end

    assign address_b = rd_any ? rd_sel_addr : addr_b_q;

    always_comb begin
        tag_in     = '0;
        tag_in.vld = rd_any;
        tag_in.id  = TAG_ID_W'(rd_idx);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            addr_b_q <= '0;
            for (int s = 0; s < RD_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            if (wr_any) wr_ptr <= ptr_inc(wr_idx);
            if (rd_any) begin
                rd_ptr   <= ptr_inc(rd_idx);
                addr_b_q <= rd_sel_addr;
            end
            tag_pipe[0] <= tag_in;
            for (int s = 1; s < RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign rd_resp_valid = tag_pipe[RD_LAT-1].vld;
    assign rd_resp_id    = tag_pipe[RD_LAT-1].id[ID_W-1:0];
    assign rd_resp_data  = rd_resp_valid & ram_valid_q_b;
    assign unused_tag_id = ^tag_pipe[RD_LAT-1].id;

endmodule
